calc1_port_sequencer: RTL and testbench

//  Upstream request master for one calc1 port; one instance per port (1..4).

---
 rtl/calc1_port_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_calc1_port_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : calc1_port_sequencer
//  Purpose  : Upstream request master for one calc1 port. Whole transactions
//             (cmd, op1, op2) arrive on a valid/ready interface and are
//             buffered in a small FIFO. Each one is serialised onto the calc1
//             two-cycle request protocol. The single-cycle calc1 response is
//             captured and returned on a valid/ready response interface. At
//             most one transaction is outstanding in calc1 at any time.
//
//  Ports    : c_clk, reset_n (synchronous, active-low)
//             req_valid/req_ready/req_cmd/req_op1/req_op2 : request in
//             rsp_valid/rsp_ready/rsp_resp/rsp_data       : response out
//             calc_cmd/calc_data                          : to calc1
//             calc_resp/calc_rdata                        : from calc1
//             busy         : FSM not idle or FIFO non-empty
//             err_spurious : sticky, calc1 response seen outside WAIT
//
//  Config   : CALC_TIMEOUT_EN - when defined, WAIT gives up after
//             TIMEOUT_CYCLES cycles and returns response code 2'b11.
//
//  Revision : 1.0 - initial release
// ============================================================================
module calc1_port_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [3:0]  calc_cmd,
    output logic [31:0] calc_data,
    input  logic [1:0]  calc_resp,
    input  logic [31:0] calc_rdata,
    output logic        busy,
    output logic        err_spurious
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SEND1 = 3'd1;
    localparam logic [2:0] c_ST_SEND2 = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [3:0]          r_fifo_cmd [FIFO_DEPTH];
    logic [31:0]         r_fifo_op1 [FIFO_DEPTH];
    logic [31:0]         r_fifo_op2 [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_timeout;

    // Ready depends only on the registered count, never on rsp_ready.
    assign w_full = (r_count == c_FULL_COUNT);
    assign w_push = req_valid & ~w_full;
    // Pop only from IDLE and only from already-registered contents, so a
    // request pushed at one edge reaches SEND1 one edge later at the earliest.
    assign w_pop  = (r_state == c_ST_IDLE) && (r_count != '0);

    always_ff @(posedge c_clk) begin
        if (w_push) begin
            r_fifo_cmd[r_wr_ptr] <= req_cmd;
            r_fifo_op1[r_wr_ptr] <= req_op1;
            r_fifo_op2[r_wr_ptr] <= req_op2;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------
`ifdef CALC_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_count;

    // Held at zero outside WAIT, so it is already clear on WAIT entry.
    always_ff @(posedge c_clk) begin
        if (!reset_n || (r_state != c_ST_WAIT)) begin
            r_to_count <= '0;
        end else begin
            r_to_count <= r_to_count + 1'b1;
        end
    end

    assign w_timeout = (r_state == c_ST_WAIT) && (r_to_count == c_TO_LAST);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register plus holding / response / error registers
    // ------------------------------------------------------------------
    logic [3:0]  r_hold_cmd;
    logic [31:0] r_hold_op1;
    logic [31:0] r_hold_op2;
    logic [1:0]  r_rsp_resp;
    logic [31:0] r_rsp_data;
    logic        r_err_spurious;

    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            r_state        <= c_ST_IDLE;
            r_hold_cmd     <= '0;
            r_hold_op1     <= '0;
            r_hold_op2     <= '0;
            r_rsp_resp     <= '0;
            r_rsp_data     <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_hold_cmd <= r_fifo_cmd[r_rd_ptr];
                r_hold_op1 <= r_fifo_op1[r_rd_ptr];
                r_hold_op2 <= r_fifo_op2[r_rd_ptr];
            end
            // A real response takes priority over a simultaneous timeout.
            if (r_state == c_ST_WAIT) begin
                if (calc_resp != 2'b00) begin
                    r_rsp_resp <= calc_resp;
                    r_rsp_data <= calc_rdata;
                end else if (w_timeout) begin
                    r_rsp_resp <= 2'b11;
                    r_rsp_data <= '0;
                end
            end
            // Includes a late response arriving after a timeout.
            if ((calc_resp != 2'b00) && (r_state != c_ST_WAIT)) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_pop) w_state_nxt = c_ST_SEND1;
            c_ST_SEND1: w_state_nxt = c_ST_SEND2;
            c_ST_SEND2: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if ((calc_resp != 2'b00) || w_timeout) w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  if (rsp_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, so they are glitch-free.
    always_comb begin
        calc_cmd  = '0;
        calc_data = '0;
        rsp_valid = 1'b0;
        rsp_resp  = '0;
        rsp_data  = '0;
        case (r_state)
            c_ST_SEND1: begin
                calc_cmd  = r_hold_cmd;
                calc_data = r_hold_op1;
            end
            c_ST_SEND2: begin
                calc_data = r_hold_op2;
            end
            c_ST_HOLD: begin
                rsp_valid = 1'b1;
                rsp_resp  = r_rsp_resp;
                rsp_data  = r_rsp_data;
            end
            default: begin
            end
        endcase
    end

    assign req_ready    = ~w_full;
    assign busy         = (r_state != c_ST_IDLE) || (r_count != '0);
    assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc1_port_sequencer
//  Purpose  : Self-checking bench for calc1_port_sequencer. A transaction
//             level model (queue of accepted requests, arithmetic result
//             function, calc1 responder with random latency) predicts every
//             response, the request serialisation, req_ready and busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_port_sequencer;

    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 64;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [3:0]  calc_cmd;
    logic [31:0] calc_data;
    logic [1:0]  calc_resp;
    logic [31:0] calc_rdata;
    logic        busy;
    logic        err_spurious;

    always #5 c_clk = ~c_clk;

    calc1_port_sequencer #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_resp     (rsp_resp),
        .rsp_data     (rsp_data),
        .calc_cmd     (calc_cmd),
        .calc_data    (calc_data),
        .calc_resp    (calc_resp),
        .calc_rdata   (calc_rdata),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } txn_t;

    txn_t q_acc[$];       // accepted, response not yet delivered (oldest = in flight)
    txn_t cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc, n_sent, n_done;
    int   phase, delay, wait_cnt;
    bit   resp_stall, exp_timeout, exp_spur;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] calc_ref(input txn_t t);
        logic [31:0] r;
        case (t.cmd)
            4'd1:    begin r = t.op1 + t.op2;          return {2'b01, r}; end
            4'd2:    begin r = t.op1 - t.op2;          return {2'b01, r}; end
            4'd5:    begin r = t.op1 << t.op2[4:0];    return {2'b01, r}; end
            4'd6:    begin r = t.op1 >> t.op2[4:0];    return {2'b01, r}; end
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    // One clock: account for handshakes at the coming edge, then observe
    // at the following falling edge and play the calc1 role.
    task automatic step();
        txn_t        t;
        logic [33:0] r;
        if (rsp_valid && rsp_ready) begin
            if (q_acc.size() == 0) begin
                check_val("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
                t = q_acc.pop_front();
                r = exp_timeout ? {2'b11, 32'h0} : calc_ref(t);
                exp_timeout = 1'b0;
                check_val("rsp_resp", {30'h0, rsp_resp}, {30'h0, r[33:32]});
                check_val("rsp_data", rsp_data, r[31:0]);
                n_done++;
            end
        end
        if (req_valid && req_ready) begin
            t = {req_cmd, req_op1, req_op2};
            q_acc.push_back(t);
            n_acc++;
        end
        @(negedge c_clk);
        case (phase)
            0: begin
                if (calc_cmd != 4'd0) begin
                    n_sent++;
                    if (q_acc.size() == 0) begin
                        check_val("send_unexpected", {28'h0, calc_cmd}, 32'h0);
                    end else begin
                        cur = q_acc[0];
                        check_val("send1_cmd", {28'h0, calc_cmd}, {28'h0, cur.cmd});
                        check_val("send1_op1", calc_data, cur.op1);
                        phase = 1;
                    end
                end else begin
                    check_val("idle_calc_data", calc_data, 32'h0);
                end
            end
            1: begin
                check_val("send2_cmd", {28'h0, calc_cmd}, 32'h0);
                check_val("send2_op2", calc_data, cur.op2);
                check_val("send_rsp_valid", {31'h0, rsp_valid}, 32'h0);
                delay = $urandom_range(0, 6);
                phase = 2;
            end
            2: begin
                check_val("wait_calc_cmd", {28'h0, calc_cmd}, 32'h0);
                check_val("wait_calc_data", calc_data, 32'h0);
                if (resp_stall) begin
                    if (!rsp_valid) wait_cnt++;
                end else begin
                    check_val("wait_rsp_valid", {31'h0, rsp_valid}, 32'h0);
                    if (delay == 0) begin
                        r = calc_ref(cur);
                        calc_resp  = r[33:32];
                        calc_rdata = r[31:0];
                        phase = 3;
                    end else begin
                        delay--;
                    end
                end
            end
            default: begin
                calc_resp  = 2'b00;
                calc_rdata = $urandom;
                check_val("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
                phase = 0;
            end
        endcase
        check_val("req_ready", {31'h0, req_ready}, {31'h0, ((n_acc - n_sent) < FIFO_DEPTH)});
        check_val("busy", {31'h0, busy}, {31'h0, (n_acc != n_done)});
        check_val("err_spurious", {31'h0, err_spurious}, {31'h0, exp_spur});
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        calc_resp  = 2'b00;
        calc_rdata = 32'h0;
        @(negedge c_clk);
        reset_n = 1'b1;
        q_acc.delete();
        n_acc = 0; n_sent = 0; n_done = 0;
        phase = 0; delay = 0; wait_cnt = 0;
        resp_stall = 1'b0; exp_timeout = 1'b0; exp_spur = 1'b0;
        check_val("rst_calc_cmd",  {28'h0, calc_cmd}, 32'h0);
        check_val("rst_calc_data", calc_data, 32'h0);
        check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("rst_rsp_resp",  {30'h0, rsp_resp}, 32'h0);
        check_val("rst_rsp_data",  rsp_data, 32'h0);
        check_val("rst_busy",      {31'h0, busy}, 32'h0);
        check_val("rst_err_spur",  {31'h0, err_spurious}, 32'h0);
        check_val("rst_req_ready", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic rand_req();
        case ($urandom_range(0, 4))
            0:       req_cmd = 4'd1;
            1:       req_cmd = 4'd2;
            2:       req_cmd = 4'd5;
            3:       req_cmd = 4'd6;
            default: req_cmd = 4'd9;
        endcase
        req_op1 = $urandom;
        req_op2 = $urandom;
    endtask

    task automatic drain(input int budget);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < budget && !(q_acc.size() == 0 && phase == 0); i++) step();
        check_val("drain_left", q_acc.size(), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] exp_r;
        int          acc0;
        int          sent0;
        req_cmd = 4'd0; req_op1 = 32'h0; req_op2 = 32'h0;
        do_reset();

        // T1: single add, no bypass, exact serialisation and result
        req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'h0000_0001; req_op2 = 32'h01FF_FFFF;
        step();
        req_valid = 1'b0;
        check_val("t1_no_bypass", {28'h0, calc_cmd}, 32'h0);
        step();
        check_val("t1_send1_cmd",  {28'h0, calc_cmd}, 32'h1);
        check_val("t1_send1_data", calc_data, 32'h0000_0001);
        step();
        check_val("t1_send2_data", calc_data, 32'h01FF_FFFF);
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        check_val("t1_rsp_resp", {30'h0, rsp_resp}, 32'h1);
        check_val("t1_rsp_data", rsp_data, 32'h0200_0000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Random traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            rand_req();
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(300);

        // T2: backpressure, capacity FIFO_DEPTH+1, stable held response
        rsp_ready = 1'b0;
        acc0  = n_acc;
        sent0 = n_sent;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            rand_req();
            if (i == 5) check_val("t2_full_ready", {31'h0, req_ready}, 32'h0);
            step();
        end
        req_valid = 1'b0;
        check_val("t2_accepted", n_acc - acc0, 32'd5);
        for (int i = 0; i < 30 && !rsp_valid; i++) step();
        exp_r = calc_ref(q_acc[0]);
        for (int i = 0; i < 10; i++) begin
            check_val("t2_hold_valid", {31'h0, rsp_valid}, 32'h1);
            check_val("t2_hold_resp", {30'h0, rsp_resp}, {30'h0, exp_r[33:32]});
            check_val("t2_hold_data", rsp_data, exp_r[31:0]);
            step();
        end
        check_val("t2_one_send", n_sent - sent0, 32'd1);
        drain(300);

        // T4: spurious response while idle
        rsp_ready = 1'b0;
        calc_resp = 2'b01; calc_rdata = 32'hDEAD_BEEF;
        exp_spur  = 1'b1;
        step();
        calc_resp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check_val("t4_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            step();
        end

        // T6: reset while WAIT with two queued
        rsp_ready  = 1'b1;
        resp_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            rand_req();
            step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20 && phase != 2; i++) step();
        step();
        check_val("t6_queued", n_acc - n_sent, 32'd2);
        do_reset();
        for (int i = 0; i < 10; i++) step();

        // T5: calc1 never answers
        rsp_ready  = 1'b0;
        resp_stall = 1'b1;
        req_valid  = 1'b1; req_cmd = 4'd1; req_op1 = 32'h5; req_op2 = 32'h6;
        step();
        req_valid = 1'b0;
`ifdef CALC_TIMEOUT_EN
        for (int i = 0; i < 300 && !rsp_valid; i++) step();
        check_val("t5_wait_cycles", wait_cnt, TIMEOUT_CYCLES);
        check_val("t5_rsp_resp", {30'h0, rsp_resp}, 32'h3);
        check_val("t5_rsp_data", rsp_data, 32'h0);
        phase       = 0;
        resp_stall  = 1'b0;
        exp_timeout = 1'b1;
        rsp_ready   = 1'b1;
        step();
        rsp_ready = 1'b0;
        calc_resp = 2'b01;
        exp_spur  = 1'b1;
        step();
        calc_resp = 2'b00;
        step();
`else
        for (int i = 0; i < 200; i++) step();
        check_val("t5_no_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("t5_still_busy", {31'h0, busy}, 32'h1);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
